// File: rtl/m_vga_timing_if.sv
// m_vga_timing_if: raster timing bundle from the timing generator to the renderer.
// o_rgb exists only when VGA_TIMING_PATTERN_EN is defined.
interface m_vga_timing_if;
    logic        o_pix_en;
    logic        vga_hs;
    logic        vga_vs;
    logic        o_de;
    logic [9:0]  o_x;
    logic [9:0]  o_y;
    logic        o_sof;
    logic        o_sol;
`ifdef VGA_TIMING_PATTERN_EN
    logic [11:0] o_rgb;
`endif

    modport master (
        output o_pix_en, vga_hs, vga_vs, o_de,
        output o_x, o_y, o_sof, o_sol
`ifdef VGA_TIMING_PATTERN_EN
        , output o_rgb
`endif
    );

    modport slave (
        input o_pix_en, vga_hs, vga_vs, o_de,
        input o_x, o_y, o_sof, o_sol
`ifdef VGA_TIMING_PATTERN_EN
        , input o_rgb
`endif
    );
endinterface

// File: rtl/m_vga_timing.sv
// m_vga_timing: 640x480@60 VGA raster timing from the board clock.
// VGA_TIMING_PATTERN_EN adds a colour-bar test pattern on o_rgb.
module m_vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    m_vga_timing_if.master vga
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_BEG   = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [3:0] div_cnt;
    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       de_nxt;
    logic       hs_nxt;
    logic       vs_nxt;

    // Outputs decode the counter values being loaded, so they all move together.
    always_comb begin
        tick  = (div_cnt == DIV_LAST);
        h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
        de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hs_nxt = (h_nxt >= HS_BEG) && (h_nxt <= HS_LAST);
        vs_nxt = (v_nxt >= VS_BEG) && (v_nxt <= VS_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            h_cnt        <= H_LAST;
            v_cnt        <= V_LAST;
            vga.o_pix_en <= 1'b0;
            vga.vga_hs   <= ~SYNC_POL;
            vga.vga_vs   <= ~SYNC_POL;
            vga.o_de     <= 1'b0;
            vga.o_x      <= '0;
            vga.o_y      <= '0;
            vga.o_sof    <= 1'b0;
            vga.o_sol    <= 1'b0;
        end else begin
            div_cnt      <= tick ? 4'd0 : div_cnt + 4'd1;
            vga.o_pix_en <= tick;
            if (tick) begin
                h_cnt      <= h_nxt;
                v_cnt      <= v_nxt;
                vga.vga_hs <= hs_nxt ? SYNC_POL : ~SYNC_POL;
                vga.vga_vs <= vs_nxt ? SYNC_POL : ~SYNC_POL;
                vga.o_de   <= de_nxt;
                vga.o_x    <= h_nxt;
                vga.o_y    <= v_nxt;
                vga.o_sof  <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
                vga.o_sol  <= (h_nxt == 10'd0);
            end
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    localparam logic [9:0] H_VLAST = 10'(H_DISP - 1);
    localparam logic [9:0] V_VLAST = 10'(V_DISP - 1);

    logic [2:0]  bar;
    logic [11:0] rgb_nxt;

    // Eight 80-pixel bars; each index bit lights one colour channel.
    always_comb begin
        bar     = 3'(h_nxt / 10'd80);
        rgb_nxt = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        if (h_nxt == 10'd0 || h_nxt == H_VLAST ||
            v_nxt == 10'd0 || v_nxt == V_VLAST) begin
            rgb_nxt = 12'hFFF;
        end
        if (!de_nxt) begin
            rgb_nxt = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.o_rgb <= 12'h000;
        end else if (tick) begin
            vga.o_rgb <= rgb_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_m_vga_timing.sv
// tb_m_vga_timing: directed vector bench for the VGA timing generator.
// A reduced-geometry instance covers frame-level behaviour in few cycles.
module tb_m_vga_timing;

    logic clk;
    logic rst_n;

    m_vga_timing_if big_if ();
    m_vga_timing_if sm_if ();

    m_vga_timing u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (big_if)
    );

    // Small raster: H 8+2+3+3=16, V 6+2+2+2=12, hs x=10..12, vs y=8..9.
    m_vga_timing #(
        .CLK_DIV(2),
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) u_sm (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (sm_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int         n;
        bit         sm;
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       de;
        logic       hs;
        logic       vs;
        logic       sof;
        logic       sol;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   errors;
    int   cur;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input bit sm, input int x, input int y,
                       input bit pe, input bit de, input bit hs, input bit vs,
                       input bit sof, input bit sol);
        vec_t v;
        v.n = n; v.sm = sm; v.x = 10'(x); v.y = 10'(y);
        v.pe = pe; v.de = de; v.hs = hs; v.vs = vs;
        v.sof = sof; v.sol = sol;
        tbl.push_back(v);
    endtask

    // Advance to 1 ns after rising edge n counted from reset release.
    task automatic goto(input int n);
        if (n > cur) begin
            repeat (n - cur) @(posedge clk);
            cur = n;
            #1;
        end
    endtask

    task automatic chk_big(input string tag, input int x, input int y,
                           input bit pe, input bit de, input bit hs,
                           input bit vs, input bit sof, input bit sol);
        chk({tag, ".x"},   int'(big_if.o_x),      x);
        chk({tag, ".y"},   int'(big_if.o_y),      y);
        chk({tag, ".pe"},  int'(big_if.o_pix_en), int'(pe));
        chk({tag, ".de"},  int'(big_if.o_de),     int'(de));
        chk({tag, ".hs"},  int'(big_if.vga_hs),   int'(hs));
        chk({tag, ".vs"},  int'(big_if.vga_vs),   int'(vs));
        chk({tag, ".sof"}, int'(big_if.o_sof),    int'(sof));
        chk({tag, ".sol"}, int'(big_if.o_sol),    int'(sol));
    endtask

    int de_cnt, hs_cnt, pe_cnt, sol_cnt, vs_cnt;
    int s_de, s_vs, s_hs, s_sof, s_bad;

    initial begin
        checks = 0;
        errors = 0;
        cur    = 0;
        rst_n  = 1'b0;

        //   n     sm  x    y   pe de hs vs sof sol
        add(1,    0, 0,   0,  0, 0, 1, 1, 0, 0);
        add(2,    0, 0,   0,  1, 1, 1, 1, 1, 1);
        add(3,    0, 0,   0,  0, 1, 1, 1, 1, 1);
        add(4,    0, 1,   0,  1, 1, 1, 1, 0, 0);
        add(176,  1, 7,   5,  1, 1, 1, 1, 0, 0);
        add(194,  1, 0,   6,  1, 0, 1, 1, 0, 1);
        add(256,  1, 15,  7,  1, 0, 1, 1, 0, 0);
        add(258,  1, 0,   8,  1, 0, 1, 0, 0, 1);
        add(278,  1, 10,  8,  1, 0, 0, 0, 0, 0);
        add(320,  1, 15,  9,  1, 0, 1, 0, 0, 0);
        add(322,  1, 0,   10, 1, 0, 1, 1, 0, 1);
        add(384,  1, 15,  11, 1, 0, 1, 1, 0, 0);
        add(386,  1, 0,   0,  1, 1, 1, 1, 1, 1);
        add(387,  1, 0,   0,  0, 1, 1, 1, 1, 1);
        add(1280, 0, 639, 0,  1, 1, 1, 1, 0, 0);
        add(1282, 0, 640, 0,  1, 0, 1, 1, 0, 0);
        add(1312, 0, 655, 0,  1, 0, 1, 1, 0, 0);
        add(1314, 0, 656, 0,  1, 0, 0, 1, 0, 0);
        add(1504, 0, 751, 0,  1, 0, 0, 1, 0, 0);
        add(1506, 0, 752, 0,  1, 0, 1, 1, 0, 0);
        add(1600, 0, 799, 0,  1, 0, 1, 1, 0, 0);
        add(1602, 0, 0,   1,  1, 1, 1, 1, 0, 1);
        add(1603, 0, 0,   1,  0, 1, 1, 1, 0, 1);

        #35;
        chk_big("rst", 0, 0, 0, 0, 1, 1, 0, 0);
`ifdef VGA_TIMING_PATTERN_EN
        chk("rst.rgb", int'(big_if.o_rgb), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cur   = 0;

        foreach (tbl[i]) begin
            vec_t v;
            string tag;
            v = tbl[i];
            goto(v.n);
            tag = $sformatf("%s@%0d", v.sm ? "sm" : "big", v.n);
            if (v.sm) begin
                chk({tag, ".x"},   int'(sm_if.o_x),      int'(v.x));
                chk({tag, ".y"},   int'(sm_if.o_y),      int'(v.y));
                chk({tag, ".pe"},  int'(sm_if.o_pix_en), int'(v.pe));
                chk({tag, ".de"},  int'(sm_if.o_de),     int'(v.de));
                chk({tag, ".hs"},  int'(sm_if.vga_hs),   int'(v.hs));
                chk({tag, ".vs"},  int'(sm_if.vga_vs),   int'(v.vs));
                chk({tag, ".sof"}, int'(sm_if.o_sof),    int'(v.sof));
                chk({tag, ".sol"}, int'(sm_if.o_sol),    int'(v.sol));
            end else begin
                chk_big(tag, int'(v.x), int'(v.y), v.pe, v.de,
                        v.hs, v.vs, v.sof, v.sol);
            end
        end

        // One big line (x=1 of y=1 .. x=0 of y=2) and one small frame.
        de_cnt = 0; hs_cnt = 0; pe_cnt = 0; sol_cnt = 0; vs_cnt = 0;
        s_de = 0; s_vs = 0; s_hs = 0; s_sof = 0; s_bad = 0;
        for (int n = 1604; n <= 3203; n++) begin
            goto(n);
            de_cnt  += int'(big_if.o_de);
            hs_cnt  += int'(!big_if.vga_hs);
            vs_cnt  += int'(!big_if.vga_vs);
            pe_cnt  += int'(big_if.o_pix_en);
            sol_cnt += int'(big_if.o_sol);
            if (n >= 1922 && n <= 2305) begin
                s_de  += int'(sm_if.o_de);
                s_vs  += int'(!sm_if.vga_vs);
                s_hs  += int'(!sm_if.vga_hs);
                s_sof += int'(sm_if.o_sof);
                if (sm_if.o_de && (sm_if.o_x >= 10'd8 || sm_if.o_y >= 10'd6))
                    s_bad++;
            end
        end
        chk("line.de_clks",  de_cnt,  1280);
        chk("line.hs_clks",  hs_cnt,  192);
        chk("line.vs_clks",  vs_cnt,  0);
        chk("line.pe_count", pe_cnt,  800);
        chk("line.sol_clks", sol_cnt, 2);
        chk("frame.de_clks", s_de,    96);
        chk("frame.vs_clks", s_vs,    64);
        chk("frame.hs_clks", s_hs,    72);
        chk("frame.sof_clk", s_sof,   2);
        chk("frame.de_out",  s_bad,   0);

`ifdef VGA_TIMING_PATTERN_EN
        goto(16172);
        chk("pat85.x",   int'(big_if.o_x),   85);
        chk("pat85.rgb", int'(big_if.o_rgb), 12'h00F);
        goto(17280);
        chk("pat639.rgb", int'(big_if.o_rgb), 12'hFFF);
        goto(17402);
        chk("pat700.rgb", int'(big_if.o_rgb), 12'h000);
`endif

        // Asynchronous reset mid-clock at (300,21).
        goto(34202);
        chk("mid.x", int'(big_if.o_x), 300);
        chk("mid.y", int'(big_if.o_y), 21);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_big("arst", 0, 0, 0, 0, 1, 1, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cur   = 0;
        goto(1);
        chk_big("rel1", 0, 0, 0, 0, 1, 1, 0, 0);
        goto(2);
        chk_big("rel2", 0, 0, 1, 1, 1, 1, 1, 1);
        goto(4);
        chk_big("rel4", 1, 0, 1, 1, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
